// File: rtl/rast_pkg.sv
// rast_pkg: shared rasterizer iterator states, bounding-box indices and MSAA step helper
package rast_pkg;
  typedef enum logic {WAIT, TEST} iter_state_t;
  localparam int LL = 0;
  localparam int UR = 1;
  localparam int X = 0;
  localparam int Y = 1;
  function automatic logic [31:0] step_from_subsample(input logic [3:0] ss, input int unsigned radix);
    logic [31:0] one;
    one = 32'd1 << radix;
    return ss[2] ? one >> 1 : ss[1] ? one >> 2 : ss[0] ? one >> 3 : one;
  endfunction
endpackage

// File: rtl/samp_row_gen.sv
// samp_row_gen: lane x positions, lane valid mask and row-end flag for one iterator step
module samp_row_gen #(
  parameter int SIGFIG = 24,
  parameter int SAMPS = 4
) (
  input  logic signed [SIGFIG-1:0]      i_x,
  input  logic signed [SIGFIG-1:0]      i_step,
  input  logic signed [SIGFIG-1:0]      i_ur_x,
  output logic [SAMPS-1:0][SIGFIG-1:0]  o_lane_x,
  output logic [SAMPS-1:0]              o_valid,
  output logic                          o_row_end,
  output logic signed [SIGFIG-1:0]      o_next_x
);
  localparam int LG = $clog2(SAMPS);
  for (genvar k = 0; k < SAMPS; k++) begin : g_lane
    logic signed [SIGFIG-1:0] w_x;
    assign w_x = i_x + i_step * SIGFIG'(k);
    assign o_lane_x[k] = w_x;
    assign o_valid[k] = (k == 0) || (w_x <= i_ur_x);
  end
  assign o_next_x = i_x + (i_step << LG);
  assign o_row_end = o_next_x > i_ur_x;
endmodule

// File: rtl/sample_iter_multi.sv
// sample_iter_multi: MSAA bbox iterator, SAMPS lanes/cycle; ITER_PERF_CNT_EN adds triCnt_U/sampCnt_U
module sample_iter_multi import rast_pkg::*; #(
  parameter int SIGFIG = 24,
  parameter int RADIX = 10,
  parameter int VERTS = 3,
  parameter int AXIS = 3,
  parameter int COLORS = 3,
  parameter int SAMPS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]     tri_R14S,
  input  logic [COLORS*SIGFIG-1:0]         color_R14U,
  input  logic [1:0][1:0][SIGFIG-1:0]      box_R14S,
  input  logic                             validTri_R14H,
  input  logic [3:0]                       subSample_RnnnnU,
  input  logic                             stall_R16H,
  output logic                             halt_RnnnnH,
  output logic [VERTS*AXIS*SIGFIG-1:0]     tri_R16S,
  output logic [COLORS*SIGFIG-1:0]         color_R16U,
  output logic [SAMPS-1:0][1:0][SIGFIG-1:0] sample_R16S,
  output logic [SAMPS-1:0]                 validSamp_R16H
`ifdef ITER_PERF_CNT_EN
  ,
  output logic [31:0]                      triCnt_U,
  output logic [31:0]                      sampCnt_U
`endif
);
  iter_state_t r_state, w_next;
  logic signed [SIGFIG-1:0] r_x, r_y, r_ll_x, r_ur_x, r_ur_y, r_step;
  logic signed [SIGFIG-1:0] w_ll_x, w_ll_y, w_ur_x, w_ur_y, w_next_x;
  logic [SAMPS-1:0][SIGFIG-1:0] w_lane_x;
  logic [SAMPS-1:0] w_valid;
  logic w_row_end, w_box_end, w_accept, w_empty;
  assign w_ll_x = $signed(box_R14S[LL][X]);
  assign w_ll_y = $signed(box_R14S[LL][Y]);
  assign w_ur_x = $signed(box_R14S[UR][X]);
  assign w_ur_y = $signed(box_R14S[UR][Y]);
  assign w_empty = (w_ll_x > w_ur_x) || (w_ll_y > w_ur_y);
  samp_row_gen #(.SIGFIG(SIGFIG), .SAMPS(SAMPS)) u_row (
    .i_x(r_x),
    .i_step(r_step),
    .i_ur_x(r_ur_x),
    .o_lane_x(w_lane_x),
    .o_valid(w_valid),
    .o_row_end(w_row_end),
    .o_next_x(w_next_x)
  );
  assign w_box_end = w_row_end && (r_y + r_step > r_ur_y);
  // halt releases on the final box cycle so the next triangle can be queued
  assign halt_RnnnnH = (r_state == TEST) && !(w_box_end && !stall_R16H);
  assign w_accept = (r_state == WAIT) && validTri_R14H && !halt_RnnnnH && !stall_R16H;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= WAIT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept && !w_empty) w_next = TEST;
    else if (r_state == TEST && !stall_R16H && w_box_end) w_next = WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
      r_ll_x <= '0;
      r_ur_x <= '0;
      r_ur_y <= '0;
      r_step <= '0;
      tri_R16S <= '0;
      color_R16U <= '0;
      sample_R16S <= '0;
      validSamp_R16H <= '0;
    end else if (!stall_R16H) begin
      validSamp_R16H <= '0;
      if (w_accept) begin
        tri_R16S <= tri_R14S;
        color_R16U <= color_R14U;
        r_x <= w_ll_x;
        r_y <= w_ll_y;
        r_ll_x <= w_ll_x;
        r_ur_x <= w_ur_x;
        r_ur_y <= w_ur_y;
        r_step <= SIGFIG'(step_from_subsample(subSample_RnnnnU, RADIX));
      end else if (r_state == TEST) begin
        for (int k = 0; k < SAMPS; k++) sample_R16S[k] <= {r_y, w_lane_x[k]};
        validSamp_R16H <= w_valid;
        if (!w_row_end) r_x <= w_next_x;
        else if (!w_box_end) begin
          r_x <= r_ll_x;
          r_y <= r_y + r_step;
        end
      end
    end
`ifdef ITER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      triCnt_U <= '0;
      sampCnt_U <= '0;
    end else begin
      if (w_accept) triCnt_U <= triCnt_U + 32'd1;
      if (!stall_R16H) sampCnt_U <= sampCnt_U + 32'($countones(validSamp_R16H));
    end
`endif
endmodule

// File: tb/tb_sample_iter_multi.sv
// tb_sample_iter_multi: directed checks of the MSAA bounding-box iterator
module tb_sample_iter_multi;
  typedef logic [3:0][1:0][23:0] samp_t;
  logic clk = 1'b0;
  logic rst;
  logic [215:0] tri_in;
  logic [71:0] color_in;
  logic [1:0][1:0][23:0] box;
  logic valid_tri, stall;
  logic [3:0] ss;
  logic halt;
  logic [215:0] tri_out;
  logic [71:0] color_out;
  samp_t samp;
  logic [3:0] vsamp;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [215:0] TRI_A = {9{24'h1A2B3C}};
  localparam logic [215:0] TRI_B = {9{24'h0F0E0D}};
  localparam logic [71:0] COL_A = {3{24'h00ABCD}};
`ifdef ITER_PERF_CNT_EN
  logic [31:0] tri_cnt, samp_cnt;
`endif
  sample_iter_multi dut (
    .clk(clk),
    .rst(rst),
    .tri_R14S(tri_in),
    .color_R14U(color_in),
    .box_R14S(box),
    .validTri_R14H(valid_tri),
    .subSample_RnnnnU(ss),
    .stall_R16H(stall),
    .halt_RnnnnH(halt),
    .tri_R16S(tri_out),
    .color_R16U(color_out),
    .sample_R16S(samp),
    .validSamp_R16H(vsamp)
`ifdef ITER_PERF_CNT_EN
    ,
    .triCnt_U(tri_cnt),
    .sampCnt_U(samp_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic samp_t row(input int x0, input int y, input int st);
    samp_t r;
    for (int k = 0; k < 4; k++) begin
      r[k][0] = 24'(x0 + k * st);
      r[k][1] = 24'(y);
    end
    return r;
  endfunction
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_row(input string tag, input samp_t es, input logic [3:0] ev, input logic eh);
    n_cmp++;
    assert (samp === es) else begin
      n_err++;
      $error("FAIL %s samples observed=%0h expected=%0h", tag, samp, es);
    end
    n_cmp++;
    assert (vsamp === ev) else begin
      n_err++;
      $error("FAIL %s valid observed=%b expected=%b", tag, vsamp, ev);
    end
    chk_bit({tag, " halt"}, halt, eh);
  endtask
  task automatic chk_idle(input string tag, input logic eh);
    n_cmp++;
    assert (vsamp === 4'b0000) else begin
      n_err++;
      $error("FAIL %s valid observed=%b expected=0000", tag, vsamp);
    end
    chk_bit({tag, " halt"}, halt, eh);
  endtask
  task automatic chk_tri(input string tag, input logic [215:0] et);
    n_cmp++;
    assert (tri_out === et) else begin
      n_err++;
      $error("FAIL %s tri observed=%0h expected=%0h", tag, tri_out, et);
    end
  endtask
  task automatic set_box(input int llx, input int lly, input int urx, input int ury, input logic [3:0] s);
    box[0][0] = 24'(llx);
    box[0][1] = 24'(lly);
    box[1][0] = 24'(urx);
    box[1][1] = 24'(ury);
    ss = s;
  endtask
  initial begin
    rst = 1'b0;
    tri_in = TRI_A;
    color_in = COL_A;
    box = '0;
    valid_tri = 1'b0;
    stall = 1'b0;
    ss = 4'b1000;
    #2;
    chk_idle("reset", 1'b0);
    chk_tri("reset", '0);
    n_cmp++;
    assert (samp === '0 && color_out === '0) else begin
      n_err++;
      $error("FAIL reset samples/color observed=%0h/%0h expected=0/0", samp, color_out);
    end
    rst = 1'b1;
    // 1x over a 6x2 box: two cycles per row, two rows
    set_box(0, 0, 5120, 1024, 4'b1000);
    valid_tri = 1'b1;
    tick();
    valid_tri = 1'b0;
    chk_idle("s1 accept", 1'b1);
    chk_tri("s1 accept", TRI_A);
    tick();
    chk_row("s1 r0a", row(0, 0, 1024), 4'b1111, 1'b1);
    tick();
    chk_row("s1 r0b", row(4096, 0, 1024), 4'b0011, 1'b1);
    tick();
    chk_row("s1 r1a", row(0, 1024, 1024), 4'b1111, 1'b0);
    tick();
    chk_row("s1 r1b", row(4096, 1024, 1024), 4'b0011, 1'b0);
    tick();
    chk_idle("s1 done", 1'b0);
    chk_tri("s1 hold", TRI_A);
`ifdef ITER_PERF_CNT_EN
    n_cmp++;
    assert (tri_cnt === 32'd1 && samp_cnt === 32'd12) else begin
      n_err++;
      $error("FAIL perf observed=%0d/%0d expected=1/12", tri_cnt, samp_cnt);
    end
`endif
    // 4x single-point box
    set_box(2048, 2048, 2048, 2048, 4'b0100);
    valid_tri = 1'b1;
    tick();
    valid_tri = 1'b0;
    chk_idle("s2 accept", 1'b0);
    tick();
    chk_row("s2 point", row(2048, 2048, 512), 4'b0001, 1'b0);
    tick();
    chk_idle("s2 done", 1'b0);
    // empty box followed immediately by a 1x point triangle
    set_box(4096, 0, 2048, 0, 4'b1000);
    tri_in = TRI_B;
    valid_tri = 1'b1;
    tick();
    chk_idle("s3 empty", 1'b0);
    chk_tri("s3 empty latch", TRI_B);
    tri_in = TRI_A;
    set_box(0, 0, 0, 0, 4'b1000);
    tick();
    valid_tri = 1'b0;
    chk_idle("s3 next accept", 1'b0);
    chk_tri("s3 next accept", TRI_A);
    tick();
    chk_row("s3 next", row(0, 0, 1024), 4'b0001, 1'b0);
    tick();
    // back-to-back with a 3-cycle stall mid-row
    set_box(0, 0, 5120, 1024, 4'b1000);
    tri_in = TRI_A;
    valid_tri = 1'b1;
    tick();
    tri_in = TRI_B;
    set_box(1024, 2048, 2048, 2048, 4'b1000);
    tick();
    chk_row("s4 r0a", row(0, 0, 1024), 4'b1111, 1'b1);
    stall = 1'b1;
    tick();
    chk_row("s4 stall1", row(0, 0, 1024), 4'b1111, 1'b1);
    tick();
    chk_row("s4 stall2", row(0, 0, 1024), 4'b1111, 1'b1);
    tick();
    chk_row("s4 stall3", row(0, 0, 1024), 4'b1111, 1'b1);
    stall = 1'b0;
    tick();
    chk_row("s4 r0b", row(4096, 0, 1024), 4'b0011, 1'b1);
    chk_tri("s4 tri a held", TRI_A);
    tick();
    chk_row("s4 r1a", row(0, 1024, 1024), 4'b1111, 1'b0);
    tick();
    chk_row("s4 r1b", row(4096, 1024, 1024), 4'b0011, 1'b0);
    tick();
    valid_tri = 1'b0;
    chk_idle("s4 b accept", 1'b0);
    chk_tri("s4 b accept", TRI_B);
    tick();
    chk_row("s4 b row", row(1024, 2048, 1024), 4'b0011, 1'b0);
    tick();
    chk_idle("s4 done", 1'b0);
    // asynchronous reset mid-TEST
    set_box(0, 0, 5120, 1024, 4'b1000);
    tri_in = TRI_A;
    valid_tri = 1'b1;
    tick();
    valid_tri = 1'b0;
    tick();
    chk_row("s5 pre-reset", row(0, 0, 1024), 4'b1111, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle("s5 reset", 1'b0);
    chk_tri("s5 reset", '0);
    n_cmp++;
    assert (samp === '0) else begin
      n_err++;
      $error("FAIL s5 reset samples observed=%0h expected=0", samp);
    end
    #2;
    rst = 1'b1;
    tri_in = TRI_B;
    set_box(1024, 2048, 2048, 2048, 4'b1000);
    valid_tri = 1'b1;
    tick();
    valid_tri = 1'b0;
    chk_tri("s5 b accept", TRI_B);
    tick();
    chk_row("s5 b row", row(1024, 2048, 1024), 4'b0011, 1'b0);
    tick();
    chk_idle("s5 done", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
